mem_arbiter: RTL and testbench

- Sequences the single byte-wide memory port between two requesters: instruction fetch (IF, 4-byte reads) and the MEM stage (1/2/4-byte loads and stores).
- Issues stall requests to the stall controller while either requester's transaction is outstanding.
- Sits between the IF/MEM stage logic and external RAM; the MEM-stage request fields come from the ex_mem pipeline register outputs.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one RAM port between instruction fetch and MEM loads/stores.
// Reads: N+1 cycles grant->done. Writes: N cycles. Waiting requesters are stalled through stallreq_*.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [1:0]            mem_sel,
    input  logic                  mem_signed,
    input  logic [31:0]           mem_wdata,
    input  logic [7:0]            ram_din,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_dout,
    output logic                  ram_wr,
    output logic                  if_done,
    output logic [31:0]           if_inst,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    output logic                  stallreq_if,
    output logic                  stallreq_mem
);

    typedef enum logic [2:0] {IDLE, IF_RD, LD, ST, RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [2:0]  len;
    logic        gnt_mem;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] rd_buf;
    logic [31:0] rd_next;
    logic [31:0] ld_ext;
    logic [1:0]  bidx;

    function automatic logic [2:0] sel_len(input logic [1:0] s);
        case (s)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = 3'd0;
                if (mem_req)     state_nxt = mem_we ? ST : LD;
                else if (if_req) state_nxt = IF_RD;
            end
            // Reads spend one extra cycle because RAM data trails its address by one cycle.
            IF_RD, LD: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt == len) state_nxt = RESP;
            end
            ST: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt == len - 3'd1) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Byte arriving in cycle cnt belongs to the address issued in cycle cnt-1.
    always_comb begin
        bidx    = cnt[1:0] - 2'd1;
        rd_next = rd_buf;
        rd_next[{bidx, 3'b000} +: 8] = ram_din;
        case (len)
            3'd1:    ld_ext = {{24{sgn & rd_next[7]}}, rd_next[7:0]};
            3'd2:    ld_ext = {{16{sgn & rd_next[15]}}, rd_next[15:0]};
            default: ld_ext = rd_next;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            len       <= 3'd0;
            gnt_mem   <= 1'b0;
            sgn       <= 1'b0;
            wdata     <= 32'h0;
            rd_buf    <= 32'h0;
            ram_addr  <= '0;
            if_inst   <= 32'h0;
            mem_rdata <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            case (state)
                IDLE: begin
                    rd_buf <= 32'h0;
                    if (mem_req) begin
                        gnt_mem  <= 1'b1;
                        len      <= sel_len(mem_sel);
                        sgn      <= mem_signed;
                        wdata    <= mem_wdata;
                        ram_addr <= mem_addr;
                    end else if (if_req) begin
                        gnt_mem  <= 1'b0;
                        len      <= 3'd4;
                        sgn      <= 1'b0;
                        ram_addr <= if_addr;
                    end
                end
                IF_RD, LD: begin
                    if (cnt < len - 3'd1) ram_addr <= ram_addr + ADDR_WIDTH'(1);
                    if (cnt != 3'd0) rd_buf <= rd_next;
                    if (cnt == len) begin
                        if (state == IF_RD) if_inst   <= rd_next;
                        else                mem_rdata <= ld_ext;
                    end
                end
                ST: begin
                    if (cnt < len - 3'd1) ram_addr <= ram_addr + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign ram_wr       = (state == ST);
    assign ram_dout     = (state == ST) ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;
    assign if_done      = (state == RESP) && !gnt_mem;
    assign mem_done     = (state == RESP) && gnt_mem;
    assign stallreq_if  = if_req && !if_done;
    assign stallreq_mem = mem_req && !mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected done/write events, a negedge monitor checks them.
module tb_mem_arbiter;

    localparam int K_IF = 0, K_MEM = 1, K_WR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, mem_signed = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [1:0]  mem_sel = '0;
    logic [7:0]  ram_din;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_wr, if_done, mem_done, stallreq_if, stallreq_mem;
    logic [31:0] if_inst, mem_rdata;

    logic [7:0]  ram [0:4095];
    logic        tb_we = 1'b0;
    logic [11:0] tb_a = '0;
    logic [7:0]  tb_d = '0;

    typedef struct {int kind; logic [31:0] a; logic [31:0] d; int cyc;} ev_t;
    ev_t q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    mem_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
        .mem_signed(mem_signed), .mem_wdata(mem_wdata),
        .ram_din(ram_din), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr),
        .if_done(if_done), .if_inst(if_inst), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Synchronous RAM: data for an address appears the cycle after it is presented.
    always @(posedge clk) begin
        ram_din <= ram[ram_addr[11:0]];
        if (ram_wr)     ram[ram_addr[11:0]] <= ram_dout;
        else if (tb_we) ram[tb_a] <= tb_d;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic ev(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        if (q.size() == 0) begin
            chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = q.pop_front();
            chk("ev_kind", 32'(kind), 32'(e.kind));
            chk("ev_addr", a, e.a);
            chk("ev_data", d, e.d);
            chk("ev_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (if_done)  ev(K_IF, 32'h0, if_inst);
        if (mem_done) ev(K_MEM, 32'h0, mem_rdata);
        if (ram_wr)   ev(K_WR, ram_addr, {24'h0, ram_dout});
    end

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        tb_a = a; tb_d = d; tb_we = 1'b1;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    // Waits for the done pulse; checks stall and the per-byte address in cycle c0+1+k.
    task automatic wait_done(input bit is_mem, input logic [31:0] a, input int n, input int c0);
        bit seen = 1'b0;
        int k;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_mem ? mem_done : if_done) begin
                seen = 1'b1;
                break;
            end
            chk("stall_wait", 32'(is_mem ? stallreq_mem : stallreq_if), 32'd1);
            k = cyc - c0 - 1;
            if (k >= 0 && k < n) chk("ram_addr_seq", ram_addr, a + 32'(k));
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        else       chk("stall_drop", 32'(is_mem ? stallreq_mem : stallreq_if), 32'd0);
        if (is_mem) mem_req = 1'b0; else if_req = 1'b0;
    endtask

    task automatic run_read(input bit is_mem, input logic [31:0] a, input logic [1:0] sel,
                            input bit sg, input logic [31:0] exp);
        int n, c0;
        n = !is_mem ? 4 : (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 4;
        @(posedge clk); #1;
        c0 = cyc;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = 1'b0; mem_addr = a; mem_sel = sel; mem_signed = sg;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        q.push_back('{is_mem ? K_MEM : K_IF, 32'h0, exp, c0 + n + 2});
        wait_done(is_mem, a, n, c0);
    endtask

    task automatic run_store(input logic [31:0] a, input logic [1:0] sel,
                             input logic [31:0] wd, input logic [31:0] keep_rdata);
        int n, c0;
        n = (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 4;
        @(posedge clk); #1;
        c0 = cyc;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = a; mem_sel = sel; mem_wdata = wd;
        for (int k = 0; k < n; k++)
            q.push_back('{K_WR, a + 32'(k), {24'h0, wd[k*8 +: 8]}, c0 + 1 + k});
        q.push_back('{K_MEM, 32'h0, keep_rdata, c0 + 1 + n});
        wait_done(1'b1, a, n, c0);
        mem_we = 1'b0;
    endtask

    initial begin
        int  c0;
        bit  seen;
        poke(12'h100, 8'h13); poke(12'h101, 8'h00); poke(12'h102, 8'h00); poke(12'h103, 8'h00);
        poke(12'h020, 8'h80);
        poke(12'hFFE, 8'h44); poke(12'hFFF, 8'h33); poke(12'h000, 8'h22); poke(12'h001, 8'h11);

        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_dout", 32'(ram_dout), 32'h0);
        chk("rst_ram_wr", 32'(ram_wr), 32'h0);
        chk("rst_if_done", 32'(if_done), 32'h0);
        chk("rst_mem_done", 32'(mem_done), 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b1;

        run_read(1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0000_0013);
        run_read(1'b1, 32'h0000_0020, 2'b00, 1'b1, 32'hFFFF_FF80);
        run_read(1'b1, 32'h0000_0020, 2'b00, 1'b0, 32'h0000_0080);
        run_store(32'h0000_0031, 2'b01, 32'hAABB_CCDD, 32'h0000_0080);
        run_read(1'b1, 32'h0000_0031, 2'b01, 1'b1, 32'hFFFF_CCDD);

        // Simultaneous requests: MEM byte load first, then RESP, an IDLE grant cycle, then the fetch.
        @(posedge clk); #1;
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h20; mem_sel = 2'b00; mem_signed = 1'b0;
        q.push_back('{K_MEM, 32'h0, 32'h0000_0080, c0 + 3});
        q.push_back('{K_IF, 32'h0, 32'h0000_0013, c0 + 10});
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_done) begin
                seen = 1'b1;
                break;
            end
            chk("both_stall_if", 32'(stallreq_if), 32'd1);
            if (mem_done) mem_req = 1'b0;
        end
        if (!seen) chk("both_timeout", 32'd0, 32'd1);
        if_req = 1'b0;

        // Reset during the third byte of a fetch aborts it; the held request restarts from byte 0.
        @(posedge clk); #1;
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        repeat (4) @(negedge clk);
        chk("abort_at_byte2", ram_addr, 32'h102);
        rst = 1'b0;
        #1;
        chk("abort_ram_addr", ram_addr, 32'h0);
        chk("abort_ram_wr", 32'(ram_wr), 32'h0);
        chk("abort_ram_dout", 32'(ram_dout), 32'h0);
        chk("abort_if_done", 32'(if_done), 32'h0);
        chk("abort_mem_done", 32'(mem_done), 32'h0);
        chk("abort_if_inst", if_inst, 32'h0);
        chk("abort_mem_rdata", mem_rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        c0 = cyc;
        q.push_back('{K_IF, 32'h0, 32'h0000_0013, c0 + 6});
        wait_done(1'b0, 32'h100, 4, c0);

        run_read(1'b1, 32'hFFFF_FFFE, 2'b10, 1'b1, 32'h1122_3344);

        repeat (5) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
